// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, FSM encoding, S-box and column-major byte helpers
// Byte i of a 128-bit block sits at bits [127-8*i -: 8]; byte (row r, column c) is i = 4*c + r.
package aes_pkg;
  localparam int NR = 10;
  localparam int KEY_W = 128;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;
  localparam logic [10:1][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  function automatic int bidx(input int r, input int c);
    return 4 * c + r;
  endfunction
  function automatic logic [7:0] get_b(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction
  // Inverse as b^254 = b^2 * b^4 * ... * b^128 (0 maps to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq, inv;
    sq = b;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: next AES-128 round key from the current one (RotWord, SubWord, rcon, XOR chain)
// Ports: i_key current round key, i_rcon round constant byte, o_key next round key.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_key
);
  logic [31:0] w_t, w_n0, w_n1, w_n2, w_n3;
  assign w_t = {sbox(i_key[23:16]), sbox(i_key[15:8]), sbox(i_key[7:0]), sbox(i_key[31:24])} ^ {i_rcon, 24'h0};
  assign w_n0 = i_key[127:96] ^ w_t;
  assign w_n1 = i_key[95:64] ^ w_n0;
  assign w_n2 = i_key[63:32] ^ w_n1;
  assign w_n3 = i_key[31:0] ^ w_n2;
  assign o_key = {w_n0, w_n1, w_n2, w_n3};
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryptor, one round per clock, key expanded on the fly
// Ports: in_valid/in_ready/in/key accept a block; out_valid/out_ready/out deliver ciphertext; busy while rounds run.
// AES_BACKPRESSURE_EN: when defined DONE holds until out_ready, otherwise out_valid is a one-cycle pulse.
module aes_round_ctrl #(
  parameter int NR = aes_pkg::NR,
  parameter int KEY_W = aes_pkg::KEY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in,
  input  logic [KEY_W-1:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KEY_W-1:0] out,
  output logic             busy
);
  import aes_pkg::*;
  fsm_e r_fsm, w_fsm_nxt;
  logic [3:0] r_round;
  logic [KEY_W-1:0] r_state, r_rk, w_rk_nxt, w_sr, w_state_nxt;
  logic w_last, w_accept, w_release;
  aes_key_step u_key_step (.i_key(r_rk), .i_rcon(RCON[r_round]), .o_key(w_rk_nxt));
  // SubBytes fused with ShiftRows: row r of column c takes the byte from column c+r.
  always_comb begin
    w_sr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_sr[127-8*bidx(r, c) -: 8] = sbox(get_b(r_state, bidx(r, (c + r) % 4)));
  end
  assign w_last = r_round == 4'(NR);
  assign w_state_nxt = (w_last ? w_sr : mix_columns(w_sr)) ^ w_rk_nxt;
  assign w_accept = in_valid && r_fsm == IDLE;
  assign out = r_state;
`ifdef AES_BACKPRESSURE_EN
  assign w_release = out_ready;
`else
  logic w_unused;
  assign w_unused = out_ready;
  assign w_release = 1'b1;
`endif
  always_comb begin
    in_ready = r_fsm == IDLE;
    busy = r_fsm == ROUND;
    out_valid = r_fsm == DONE;
    w_fsm_nxt = r_fsm == IDLE ? (in_valid ? ROUND : IDLE) :
                r_fsm == ROUND ? (w_last ? DONE : ROUND) :
                w_release ? IDLE : DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= IDLE;
      r_state <= '0;
      r_rk <= '0;
      r_round <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (w_accept) begin
        r_state <= in ^ key;
        r_rk <= key;
        r_round <= 4'd1;
      end else if (busy) begin
        r_state <= w_state_nxt;
        r_rk <= w_rk_nxt;
        r_round <= w_last ? 4'd0 : r_round + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: randomized scoreboard bench for aes_round_ctrl against a byte-array AES-128 model
module tb_aes_round_ctrl;
`ifdef AES_BACKPRESSURE_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif
  localparam logic [127:0] B_PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [127:0] pt = '0, ky = '0, ct;
  logic [127:0] last_out = '0;
  int ncmp = 0, nfail = 0, nxfer = 0, cyc = 0;
  logic [7:0] sb [256];
  typedef struct {logic [127:0] exp; int acc;} exp_t;
  exp_t sbq [$];
  aes_round_ctrl dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(pt), .key(ky),
                      .out_valid(out_valid), .out_ready(out_ready), .out(ct), .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    while (y != 0) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction
  // S-box table built by walking the multiplicative group with generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask
  // State after nr rounds of AES-128 (nr=10 gives the ciphertext).
  function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0] rc;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = (rd == 10) ? t[4*c+r] :
                     gm(8'h02, t[4*c+r]) ^ gm(8'h03, t[4*c+(r+1)%4]) ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd+i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction
  // Monitor: samples just after each falling edge, where stimulus is already settled for the next rising edge.
  initial begin
    bit prev_xfer, prev_ov, xfer;
    exp_t e;
    prev_xfer = 0; prev_ov = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        sbq.delete();
        prev_xfer = 0; prev_ov = 0;
        continue;
      end
      if (prev_xfer) begin
        chk("post_xfer_out_valid", out_valid, 0);
        chk("post_xfer_in_ready", in_ready, 1);
      end
      chk("in_ready_vs_inflight", in_ready, sbq.size() == 0);
      if (sbq.size() != 0 && !out_valid) chk("busy_in_flight", busy, 1);
      if (out_valid) chk("busy_when_done", busy, 0);
      if (out_valid && sbq.size() == 0) chk("spurious_out_valid", out_valid, 0);
      // out_valid is first presented in the cycle after the 10th edge following accept, so the consumer sees it at edge 11.
      if (out_valid && !prev_ov && sbq.size() != 0) chk("latency", cyc - sbq[0].acc, 10);
      if (out_valid && sbq.size() != 0) chk("ciphertext", ct, sbq[0].exp);
      xfer = out_valid && (out_ready || !BP);
      if (xfer && sbq.size() != 0) begin
        last_out = ct;
        void'(sbq.pop_front());
        nxfer++;
      end
      if (in_valid && in_ready) begin
        e.exp = aes_ref(pt, ky, 10);
        e.acc = cyc + 1;
        sbq.push_back(e);
      end
      prev_xfer = xfer; prev_ov = out_valid;
    end
  end
  task automatic send(input logic [127:0] p, input logic [127:0] k);
    @(negedge clk);
    in_valid = 1'b1; pt = p; ky = k;
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic run_block(input string nm, input logic [127:0] p, input logic [127:0] k, input logic [127:0] exp);
    int t;
    t = nxfer;
    send(p, k);
    for (int i = 0; i < 40 && nxfer == t; i++) @(negedge clk);
    #2;
    chk({nm, "_done"}, nxfer > t, 1);
    chk(nm, last_out, exp);
  endtask
  task automatic wait_ov();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (out_valid) break;
    end
    chk("out_valid_seen", out_valid, 1);
  endtask
  task automatic check_idle_reset(input string nm);
    chk({nm, "_in_ready"}, in_ready, 1);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_out"}, ct, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    build_sbox();
    out_ready = BP;
    repeat (3) @(negedge clk);
    #2;
    check_idle_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    run_block("kat_b", B_PT, B_KEY, B_CT);
    // Round-by-round view of App. C.1: out mirrors the state register.
    send(C_PT, C_KEY);
    #2;
    chk("c1_round0", ct, C_PT ^ C_KEY);
    @(negedge clk);
    #2;
    chk("c1_round1", ct, aes_ref(C_PT, C_KEY, 1));
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    #2;
    chk("kat_c1", last_out, C_CT);
    // Back-to-back with in/key churning every cycle; only values at an accepting edge matter.
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; pt = B_PT; ky = B_KEY;
    repeat (30) begin
      @(negedge clk);
      pt = {$urandom, $urandom, $urandom, $urandom};
      ky = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid = 1'b0;
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    chk("b2b_drain", sbq.size(), 0);
    // Abort during round 5.
    send(B_PT, B_KEY);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_idle_reset("abort");
    run_block("kat_b_after_abort", B_PT, B_KEY, B_CT);
    out_ready = 1'b0;
`ifdef AES_BACKPRESSURE_EN
    send(B_PT, B_KEY);
    wait_ov();
    repeat (20) begin
      @(negedge clk);
      #2;
      chk("stall_out", ct, B_CT);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #2;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
`else
    send(C_PT, C_KEY);
    wait_ov();
    chk("pulse_out", ct, C_CT);
    @(negedge clk);
    #2;
    chk("pulse_out_valid", out_valid, 0);
    chk("pulse_in_ready", in_ready, 1);
`endif
    repeat (300) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 2) != 0);
      pt = {$urandom, $urandom, $urandom, $urandom};
      ky = {$urandom, $urandom, $urandom, $urandom};
      out_ready = $urandom_range(0, 1) != 0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    #2;
    chk("final_drain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
